mips_lsu: RTL and testbench

Parametrised load/store unit for the MIPS core, replacing the fixed word-plus-SB memory path. Accepts one load or store per handshake from the datapath and generates byte enables, lane-replicated store data and sign/zero-extended load data for byte, halfword, word and (64-bit builds) doubleword accesses. Talks to data memory over a req/ack handshake with variable latency and a watchdog timeout. Sits between the datapath (ALU address, register write data, result mux) and data memory.

---
 rtl/mips_lsu_pkg.sv | 42 ++++
 rtl/mips_lsu_align.sv | 65 ++++++
 rtl/mips_lsu.sv | 177 +++++++++++++++++
 tb/tb_mips_lsu.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared types, error codes and lane-mask helpers for the MIPS load/store unit
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  // Byte-enable pattern of an access at lane offset 0.
  function automatic logic [7:0] be_mask(input size_e size);
    case (size)
      SZ_B:    be_mask = 8'h01;
      SZ_H:    be_mask = 8'h03;
      SZ_W:    be_mask = 8'h0F;
      default: be_mask = 8'hFF;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] low_mask(input size_e size);
    case (size)
      SZ_B:    low_mask = 3'd0;
      SZ_H:    low_mask = 3'd1;
      SZ_W:    low_mask = 3'd3;
      default: low_mask = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// rtl/mips_lsu_align.sv - combinational lane steering: byte enables, store replication, load extract/extend
module mips_lsu_align
  import mips_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  size_e             size_i,
  input  logic              unsigned_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sign_bit;

  // Size mask moved up to the addressed lane; offset is already size-aligned so nothing spills.
  always_comb begin
    be_o = BE_W'({8'h00, be_mask(size_i)} << offset_i);
  end

  // Replicate the low byte/half/word of the store data into every lane.
  always_comb begin
    wdata_o = '0;
    for (int i = 0; i < BE_W; i++) begin
      case (size_i)
        SZ_B:    wdata_o[i*8 +: 8] = wdata_i[7:0];
        SZ_H:    wdata_o[i*8 +: 8] = wdata_i[(i%2)*8 +: 8];
        SZ_W:    wdata_o[i*8 +: 8] = wdata_i[(i%4)*8 +: 8];
        default: wdata_o[i*8 +: 8] = wdata_i[i*8 +: 8];
      endcase
    end
  end

  // Right-justify the addressed lane, keep the access width and fill the rest with sign or zero.
  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SZ_B: begin
        keep     = DATA_W'(64'hFF);
        sign_bit = shifted[7];
      end
      SZ_H: begin
        keep     = DATA_W'(64'hFFFF);
        sign_bit = shifted[15];
      end
      SZ_W: begin
        keep     = DATA_W'(64'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: begin
        keep     = '1;
        sign_bit = shifted[DATA_W-1];
      end
    endcase
    rdata_o = (shifted & keep) | ((sign_bit && !unsigned_i) ? ~keep : '0);
  end

endmodule

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - load/store unit top (req/ack memory, watchdog); LSU_MISALIGN_TRAP_EN enables alignment traps
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int WD_W  = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                capture;

  logic                we_q;
  size_e               size_q;
  logic                uns_q;
  logic [ADDR_W-OFF_W-1:0] line_q;
  logic [OFF_W-1:0]    off_q;
  logic [DATA_W-1:0]   wdata_q;

  size_e               req_size_e;
  logic [OFF_W-1:0]    req_lmask;
  logic [OFF_W-1:0]    req_off;
  logic                req_illegal;
  logic                req_misalign;

  logic [BE_W-1:0]     lane_be;
  logic [DATA_W-1:0]   lane_wdata;
  logic [DATA_W-1:0]   lane_rdata;
  logic                in_access;
  logic                in_resp;

  assign req_size_e  = size_e'(req_size);
  assign req_lmask   = OFF_W'(low_mask(req_size_e));
  // Without the trap the sub-size address bits are simply dropped.
  assign req_off     = req_addr[OFF_W-1:0] & ~req_lmask;
  assign req_illegal = (DATA_W == 32) && (req_size_e == SZ_D);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misalign = |(req_addr[OFF_W-1:0] & req_lmask);
`else
  assign req_misalign = 1'b0;
`endif

  mips_lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .offset_i   (off_q),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  // Next state, watchdog and response capture.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          wd_d    = '0;
          rdata_d = '0;
          if (req_illegal) begin
            state_d = ST_RESP;
            err_d   = ERR_SIZE;
          end else if (req_misalign) begin
            state_d = ST_RESP;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = ST_ACCESS;
            err_d   = ERR_OK;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d = ST_RESP;
          err_d   = ERR_OK;
          rdata_d = we_q ? '0 : lane_rdata;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle spent waiting.
          state_d = ST_RESP;
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and response registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields held for the whole access so the memory side sees stable values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      line_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= req_we;
      size_q  <= req_size_e;
      uns_q   <= req_unsigned;
      line_q  <= req_addr[ADDR_W-1:OFF_W];
      off_q   <= req_off;
      wdata_q <= req_wdata;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = in_resp;
  assign rsp_err   = in_resp ? err_q : ERR_OK;
  assign rsp_rdata = in_resp ? rdata_q : '0;

  assign mem_req   = in_access;
  assign mem_we    = in_access && we_q;
  assign mem_addr  = in_access ? {line_q, {OFF_W{1'b0}}} : '0;
  assign mem_be    = in_access ? lane_be : '0;
  assign mem_wdata = (in_access && we_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_mips_lsu.sv
// tb/tb_mips_lsu.sv - scoreboard bench for mips_lsu with a behavioural memory-side model
`timescale 1ns/1ps
module tb_mips_lsu;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int BE_W    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  mips_lsu #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    int          edge_n;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    bit          noack;
  } mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   force_ack = 1'b0;
  bit   in_acc = 1'b0;
  int   acc_cnt = 0;
  mem_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request from a negedge; the reference response and memory access are queued first.
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int lat, input bit noack,
                       input bit expect_rsp);
    int              nbytes;
    int              off;
    int              a;
    int              guard;
    rsp_t            r;
    mem_t            m;
    longint unsigned span;
    longint unsigned v;
    longint unsigned rdl;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", req_ready, 1);
    a      = cyc + 1;
    nbytes = 1 << sz;
    r.rdata = 32'h0;
    r.err   = 2'b00;
    if (sz == 2'b11) begin
      r.err    = 2'b11;
      r.edge_n = a + 1;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    else if (addr % nbytes != 0) begin
      r.err    = 2'b01;
      r.edge_n = a + 1;
    end
`endif
    else begin
      off     = (addr % BE_W) / nbytes * nbytes;
      m.we    = we;
      m.addr  = addr - (addr % BE_W);
      m.be    = 4'(((1 << nbytes) - 1) << off);
      m.wdata = 32'h0;
      for (int i = 0; i < BE_W; i++) m.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
      m.rdata = rd;
      m.lat   = lat;
      m.noack = noack;
      mem_q.push_back(m);
      if (noack) begin
        r.err    = 2'b10;
        r.edge_n = a + TIMEOUT + 1;
      end else begin
        r.edge_n = a + 2 + lat;
        if (!we) begin
          rdl  = rd;
          span = 64'd1 << (8 * nbytes);
          v    = (rdl >> (8 * off)) % span;
          if (!uns && v >= span / 2) v = (64'd1 << 32) + v - span;
          r.rdata = v[31:0];
        end
      end
    end
    if (expect_rsp) rsp_q.push_back(r);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(negedge clk);
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Memory responder: checks the access presented and acks after the scripted latency.
  initial begin : responder
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack   = force_ack;
      mem_rdata = $urandom;
      if (!mem_req) begin
        in_acc = 1'b0;
        if (!force_ack) mem_ack = ($urandom_range(3) == 0);
      end else begin
        if (!in_acc) begin
          in_acc  = 1'b1;
          acc_cnt = 0;
          if (mem_q.size() == 0) begin
            chk("mem_unexpected", mem_req, 0);
            cur = '{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, rdata: 32'h0, lat: 0, noack: 1'b1};
          end else begin
            cur = mem_q.pop_front();
          end
        end
        chk("ready_low_access", req_ready, 0);
        chk("mem_we", mem_we, cur.we);
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_be", mem_be, cur.be);
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        if (!cur.noack && acc_cnt == cur.lat) begin
          mem_ack   = 1'b1;
          mem_rdata = cur.rdata;
        end
        acc_cnt++;
      end
    end
  end

  // Response monitor: every rsp_valid pops one reference entry.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_edge", cyc + 1, e.edge_n);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    bit we;
    logic [1:0] sz;
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b1;
    @(negedge clk);

    issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 1'b0, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_2001, $urandom, 32'h0000_8000, 1, 1'b0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_2001, $urandom, 32'h0000_8000, 0, 1'b0, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, $urandom, 32'h8001_0000, 3, 1'b0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3002, $urandom, 32'hCAFE_F00D, 0, 1'b0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_3004, 32'h1234_5678, 32'h0, 2, 1'b0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, $urandom, 32'h0, 0, 1'b1, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_4000, $urandom, 32'h0, 0, 1'b0, 1'b1);

    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom);
      sz = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
      issue(we, sz, 1'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(4), ($urandom_range(9) == 0), 1'b1);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    // Reset in the middle of an access, followed by a late ack that must be ignored.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, $urandom, 32'h0, 0, 1'b1, 1'b0);
    chk("acc_before_reset", mem_req, 1);
    reset = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_mem_req", mem_req, 0);
    chk("post_rst_rsp", rsp_valid, 0);
    @(negedge clk);
    force_ack = 1'b0;
    chk("late_ack_rsp", rsp_valid, 0);
    chk("late_ack_ready", req_ready, 1);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_7006, $urandom, 32'h9ABC_0000, 1, 1'b0, 1'b1);

    guard = 0;
    while (rsp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    chk("rsp_drain", rsp_q.size(), 0);
    chk("mem_drain", mem_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
